// File: rtl/am_query_scheduler.sv
// Query sequencer for the associative-memory datapath: accepts one encoded query at a time,
// starts the AM, waits a fixed latency, reports the inference and counts completed samples.
module am_query_scheduler #(
   parameter int AM_LATENCY       = 12,
   parameter int NUM_TEST_SAMPLES = 1000,
   parameter int CNT_W            = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dataset_restart,
   input  logic             q_valid,
   input  logic [4:0]       q_class,
   output logic             q_ready,
   output logic             query_load,
   output logic             start_querying,
   output logic [4:0]       correct_class,
   input  logic [4:0]       class_inference,
   output logic             result_valid,
   output logic [4:0]       last_inference,
   output logic [CNT_W-1:0] sample_count,
   output logic             testing_dataset_finished,
   output logic             busy
);

   // A latency of 1 still needs a one-bit counter that simply sits at zero.
   localparam int WAIT_W = (AM_LATENCY > 1) ? $clog2(AM_LATENCY) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_START  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(AM_LATENCY - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_TEST_SAMPLES);

   if ((NUM_TEST_SAMPLES > (2 ** CNT_W) - 1) || (AM_LATENCY < 1)) begin : g_param_check
      $error("am_query_scheduler: CNT_W cannot hold NUM_TEST_SAMPLES, or AM_LATENCY < 1");
   end

   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_ctr_q, wait_ctr_d;
   logic [CNT_W-1:0]  sample_count_q, sample_count_d;
   logic [4:0]        correct_class_q, correct_class_d;
   logic [4:0]        last_inference_q, last_inference_d;
   logic              finished_q, finished_d;
   logic              busy_q, busy_d;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_d          = state_q;
      wait_ctr_d       = wait_ctr_q;
      sample_count_d   = sample_count_q;
      correct_class_d  = correct_class_q;
      last_inference_d = last_inference_q;
      q_ready          = 1'b0;
      query_load       = 1'b0;
      start_querying   = 1'b0;
      result_valid     = 1'b0;

      // Restart beats enable, so an abort still lands while the AM is frozen.
      if (dataset_restart) begin
         state_d        = ST_IDLE;
         sample_count_d = '0;
      end else if (en && !rst) begin
         case (state_q)
            ST_IDLE: begin
               q_ready = 1'b1;
               if (q_valid) begin
                  query_load      = 1'b1;
                  correct_class_d = q_class;
                  state_d         = ST_START;
               end
            end
            ST_START: begin
               start_querying = 1'b1;
               wait_ctr_d     = WAIT_INIT;
               state_d        = ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_ctr_q == '0) begin
                  result_valid     = 1'b1;
                  last_inference_d = class_inference;
                  sample_count_d   = sample_count_q + 1'b1;
                  state_d          = (sample_count_d == CNT_LAST) ? ST_FINISH : ST_IDLE;
               end else begin
                  wait_ctr_d = wait_ctr_q - 1'b1;
               end
            end
            default: ;
         endcase
      end

      finished_d = (state_d == ST_FINISH);
      busy_d     = (state_d == ST_START) || (state_d == ST_WAIT);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge value of its _d input regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         wait_ctr_q       <= '0;
         sample_count_q   <= '0;
         correct_class_q  <= '0;
         last_inference_q <= '0;
         finished_q       <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         wait_ctr_q       <= wait_ctr_d;
         sample_count_q   <= sample_count_d;
         correct_class_q  <= correct_class_d;
         last_inference_q <= last_inference_d;
         finished_q       <= finished_d;
         busy_q           <= busy_d;
      end
   end

   assign correct_class            = correct_class_q;
   assign last_inference           = last_inference_q;
   assign sample_count             = sample_count_q;
   assign testing_dataset_finished = finished_q;
   assign busy                     = busy_q;

endmodule

// File: tb/tb_am_query_scheduler.sv
// Self-checking bench for am_query_scheduler: directed timing scenarios plus a randomized run
// against a reference model that tracks elapsed enabled cycles since each accept.
module tb_am_query_scheduler;

   localparam int LAT = 12;
   localparam int N   = 3;
   localparam int CW  = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          dataset_restart;
   logic          q_valid;
   logic [4:0]    q_class;
   logic          q_ready;
   logic          query_load;
   logic          start_querying;
   logic [4:0]    correct_class;
   logic [4:0]    class_inference;
   logic          result_valid;
   logic [4:0]    last_inference;
   logic [CW-1:0] sample_count;
   logic          testing_dataset_finished;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: is a query in flight, how many enabled cycles since its accept, totals.
   bit       m_active;
   int       m_elapsed;
   int       m_count;
   bit       m_finished;
   bit [4:0] m_cc;
   bit [4:0] m_li;

   am_query_scheduler #(
      .AM_LATENCY      (LAT),
      .NUM_TEST_SAMPLES(N),
      .CNT_W           (CW)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .en                      (en),
      .dataset_restart         (dataset_restart),
      .q_valid                 (q_valid),
      .q_class                 (q_class),
      .q_ready                 (q_ready),
      .query_load              (query_load),
      .start_querying          (start_querying),
      .correct_class           (correct_class),
      .class_inference         (class_inference),
      .result_valid            (result_valid),
      .last_inference          (last_inference),
      .sample_count            (sample_count),
      .testing_dataset_finished(testing_dataset_finished),
      .busy                    (busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_active = 0; m_elapsed = 0; m_count = 0; m_finished = 0; m_cc = '0; m_li = '0;
   endtask

   task automatic model_comb(output bit e_qr, output bit e_ql, output bit e_sq, output bit e_rv);
      bit go;
      go   = en && !dataset_restart;
      e_qr = go && !m_active && !m_finished;
      e_ql = e_qr && q_valid;
      e_sq = go && m_active && (m_elapsed == 0);
      e_rv = go && m_active && (m_elapsed == LAT);
   endtask

   task automatic model_clock();
      bit e_qr, e_ql, e_sq, e_rv;
      model_comb(e_qr, e_ql, e_sq, e_rv);
      if (dataset_restart) begin
         m_active = 0; m_count = 0; m_finished = 0;
      end else if (en) begin
         if (e_ql) begin
            m_active = 1; m_elapsed = 0; m_cc = q_class;
         end else if (e_rv) begin
            m_active = 0; m_li = class_inference; m_count++;
            m_finished = (m_count == N);
         end else if (m_active) begin
            m_elapsed++;
         end
      end
   endtask

   task automatic drive_idle();
      en = 1'b1; dataset_restart = 1'b0; q_valid = 1'b0; q_class = '0; class_inference = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      drive_idle();
      model_reset();
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (q_ready !== 1'b0) begin
         n_errors++; $display("FAIL reset_q_ready_during got=%b exp=0", q_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({query_load, start_querying, result_valid, testing_dataset_finished, busy} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_pulses got=%b exp=00000",
                  {query_load, start_querying, result_valid, testing_dataset_finished, busy});
      end
      n_checks++;
      if (correct_class !== 5'd0 || last_inference !== 5'd0 || sample_count !== '0) begin
         n_errors++;
         $display("FAIL reset_regs got cc=%0d li=%0d cnt=%0d exp=0,0,0",
                  correct_class, last_inference, sample_count);
      end
      n_checks++;
      if (q_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_q_ready_after got=%b exp=1", q_ready);
      end
   endtask

   task automatic test_single_query();
      do_reset(2);
      for (int c = 0; c <= 14; c++) begin
         q_valid = (c == 0);
         q_class = (c == 0) ? 5'd7 : 5'($urandom);
         class_inference = (c == 13) ? 5'd19 : 5'($urandom);
         #1;
         n_checks++;
         if (query_load !== (c == 0) || start_querying !== (c == 1) || result_valid !== (c == 13)) begin
            n_errors++;
            $display("FAIL single_pulses c=%0d got ql=%b sq=%b rv=%b exp ql=%b sq=%b rv=%b",
                     c, query_load, start_querying, result_valid, c == 0, c == 1, c == 13);
         end
         if (c >= 1) begin
            n_checks++;
            if (correct_class !== 5'd7) begin
               n_errors++; $display("FAIL single_cc c=%0d got=%0d exp=7", c, correct_class);
            end
         end
         if (c == 14) begin
            n_checks++;
            if (sample_count !== 11'd1 || last_inference !== 5'd19 || busy !== 1'b0) begin
               n_errors++;
               $display("FAIL single_result got cnt=%0d li=%0d busy=%b exp cnt=1 li=19 busy=0",
                        sample_count, last_inference, busy);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      do_reset(2);
      q_valid = 1'b1;
      for (int c = 0; c <= 50; c++) begin
         bit e_ql, e_rv;
         q_class = 5'(c);
         e_ql = (c == 0) || (c == 14) || (c == 28);
         e_rv = (c == 13) || (c == 27) || (c == 41);
         #1;
         n_checks++;
         if (query_load !== e_ql || result_valid !== e_rv || testing_dataset_finished !== (c >= 42)) begin
            n_errors++;
            $display("FAIL b2b c=%0d got ql=%b rv=%b fin=%b exp ql=%b rv=%b fin=%b",
                     c, query_load, result_valid, testing_dataset_finished, e_ql, e_rv, c >= 42);
         end
         if (c >= 42) begin
            n_checks++;
            if (q_ready !== 1'b0) begin
               n_errors++; $display("FAIL b2b_q_ready c=%0d got=%b exp=0", c, q_ready);
            end
         end
         if (c == 20) begin
            n_checks++;
            if (correct_class !== 5'd14) begin
               n_errors++; $display("FAIL b2b_cc got=%0d exp=14", correct_class);
            end
         end
         next_cycle();
      end
      n_checks++;
      if (sample_count !== 11'd3) begin
         n_errors++; $display("FAIL b2b_count got=%0d exp=3", sample_count);
      end
      q_valid = 1'b0;
   endtask

   task automatic test_enable_freeze();
      do_reset(2);
      for (int c = 0; c <= 20; c++) begin
         en      = !(c >= 5 && c <= 8);
         q_valid = (c == 0);
         #1;
         n_checks++;
         if (result_valid !== (c == 17) || start_querying !== (c == 1)) begin
            n_errors++;
            $display("FAIL freeze_pulses c=%0d got sq=%b rv=%b exp sq=%b rv=%b",
                     c, start_querying, result_valid, c == 1, c == 17);
         end
         if (!en) begin
            n_checks++;
            if ({q_ready, query_load, start_querying, result_valid} !== 4'b0) begin
               n_errors++;
               $display("FAIL freeze_gated c=%0d got=%b exp=0000",
                        c, {q_ready, query_load, start_querying, result_valid});
            end
         end
         if (c == 17 || c == 18) begin
            n_checks++;
            if (sample_count !== CW'(c - 17)) begin
               n_errors++; $display("FAIL freeze_count c=%0d got=%0d exp=%0d", c, sample_count, c - 17);
            end
         end
         next_cycle();
      end
      en = 1'b1;
   endtask

   task automatic test_restart();
      do_reset(2);
      // Restart coinciding with an offered query in IDLE.
      dataset_restart = 1'b1; q_valid = 1'b1;
      #1;
      n_checks++;
      if (q_ready !== 1'b0 || query_load !== 1'b0) begin
         n_errors++; $display("FAIL restart_idle got qr=%b ql=%b exp 0 0", q_ready, query_load);
      end
      next_cycle();
      dataset_restart = 1'b0; q_valid = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++; $display("FAIL restart_idle_busy got=%b exp=0", busy);
      end
      // Restart on the very cycle the result would fire.
      for (int c = 0; c <= 30; c++) begin
         q_valid = (c == 0);
         dataset_restart = (c == 13);
         #1;
         n_checks++;
         if (result_valid !== 1'b0) begin
            n_errors++; $display("FAIL restart_last_wait c=%0d got rv=%b exp=0", c, result_valid);
         end
         if (c == 14) begin
            n_checks++;
            if (sample_count !== '0 || busy !== 1'b0) begin
               n_errors++;
               $display("FAIL restart_last_state got cnt=%0d busy=%b exp 0 0", sample_count, busy);
            end
         end
         next_cycle();
      end
      // Restart mid-WAIT with two samples already counted.
      for (int c = 0; c <= 50; c++) begin
         q_valid = (c <= 28);
         dataset_restart = (c == 35);
         #1;
         if (c >= 29) begin
            n_checks++;
            if (result_valid !== 1'b0) begin
               n_errors++; $display("FAIL restart_wait_rv c=%0d got=%b exp=0", c, result_valid);
            end
         end
         if (c == 35) begin
            n_checks++;
            if (sample_count !== 11'd2 || busy !== 1'b1) begin
               n_errors++;
               $display("FAIL restart_wait_pre got cnt=%0d busy=%b exp 2 1", sample_count, busy);
            end
         end
         if (c == 36) begin
            n_checks++;
            if (sample_count !== '0 || busy !== 1'b0 || q_ready !== 1'b1) begin
               n_errors++;
               $display("FAIL restart_wait_post got cnt=%0d busy=%b qr=%b exp 0 0 1",
                        sample_count, busy, q_ready);
            end
         end
         next_cycle();
      end
      // Restart out of FINISH.
      for (int c = 0; c <= 46; c++) begin
         q_valid = (c <= 28);
         dataset_restart = (c == 44);
         #1;
         if (c == 42) begin
            n_checks++;
            if (testing_dataset_finished !== 1'b1) begin
               n_errors++; $display("FAIL restart_fin_pre got=%b exp=1", testing_dataset_finished);
            end
         end
         if (c == 45) begin
            n_checks++;
            if (testing_dataset_finished !== 1'b0 || sample_count !== '0 || q_ready !== 1'b1) begin
               n_errors++;
               $display("FAIL restart_fin_post got fin=%b cnt=%0d qr=%b exp 0 0 1",
                        testing_dataset_finished, sample_count, q_ready);
            end
         end
         next_cycle();
      end
      dataset_restart = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset(2);
      q_class = 5'd9; class_inference = 5'd21;
      for (int c = 0; c <= 20; c++) begin
         q_valid = (c == 0) || (c == 14);
         #1;
         if (c < 20) next_cycle();
      end
      n_checks++;
      if (sample_count !== 11'd1 || busy !== 1'b1 || correct_class !== 5'd9) begin
         n_errors++;
         $display("FAIL async_pre got cnt=%0d busy=%b cc=%0d exp 1 1 9", sample_count, busy, correct_class);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({q_ready, query_load, start_querying, result_valid, busy, testing_dataset_finished} !== 6'b0 ||
          correct_class !== 5'd0 || last_inference !== 5'd0 || sample_count !== '0) begin
         n_errors++;
         $display("FAIL async_now got flags=%b cc=%0d li=%0d cnt=%0d exp all 0",
                  {q_ready, query_load, start_querying, result_valid, busy, testing_dataset_finished},
                  correct_class, last_inference, sample_count);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; q_valid = 1'b0;
      model_reset();
      for (int c = 0; c < 20; c++) begin
         #1;
         n_checks++;
         if (result_valid !== 1'b0 || busy !== 1'b0 || sample_count !== '0) begin
            n_errors++;
            $display("FAIL async_after c=%0d got rv=%b busy=%b cnt=%0d exp 0 0 0",
                     c, result_valid, busy, sample_count);
         end
         next_cycle();
      end
   endtask

   task automatic test_random();
      do_reset(2);
      for (int c = 0; c < 1500; c++) begin
         bit e_qr, e_ql, e_sq, e_rv;
         en              = ($urandom_range(0, 9) != 0);
         dataset_restart = ($urandom_range(0, 79) == 0);
         q_valid         = ($urandom_range(0, 2) != 0);
         q_class         = 5'($urandom);
         class_inference = 5'($urandom);
         #1;
         model_comb(e_qr, e_ql, e_sq, e_rv);
         n_checks++;
         if ({q_ready, query_load, start_querying, result_valid} !== {e_qr, e_ql, e_sq, e_rv}) begin
            n_errors++;
            $display("FAIL rand_pulses c=%0d got qr/ql/sq/rv=%b exp=%b",
                     c, {q_ready, query_load, start_querying, result_valid}, {e_qr, e_ql, e_sq, e_rv});
         end
         n_checks++;
         if (busy !== m_active || testing_dataset_finished !== m_finished || sample_count !== CW'(m_count) ||
             correct_class !== m_cc || last_inference !== m_li) begin
            n_errors++;
            $display("FAIL rand_regs c=%0d got busy=%b fin=%b cnt=%0d cc=%0d li=%0d exp %b %b %0d %0d %0d",
                     c, busy, testing_dataset_finished, sample_count, correct_class, last_inference,
                     m_active, m_finished, m_count, m_cc, m_li);
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_single_query();
      test_back_to_back();
      test_enable_freeze();
      test_restart();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
